// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches words from an external microcode ROM, handles
// jumps, branches and halt internally, and issues all other opcodes to the datapath.
module microcode_sequencer #(
  parameter int ROM_addressBits = 6,
  parameter int RF_addressBits  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          dp_ready,
  input  logic                          flag_z,
  input  logic                          flag_n,
  output logic                          ROM_readEnable,
  output logic [ROM_addressBits-1:0]    ROM_address,
  input  logic [4+2*RF_addressBits:0]   ROM_data,
  output logic [3:0]                    opcode,
  output logic [RF_addressBits-1:0]     ra,
  output logic [RF_addressBits-1:0]     rb,
  output logic                          instr_valid,
  output logic                          halted
);

  localparam int R = RF_addressBits;

  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_BRZ  = 4'b1101;
  localparam logic [3:0] OP_BRN  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [ROM_addressBits-1:0] PC_ZERO = '0;
  localparam logic [ROM_addressBits-1:0] PC_ONE  = 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    HALT
  } state_t;

  state_t                     state;
  logic [ROM_addressBits-1:0] pc;
  logic [ROM_addressBits-1:0] pc_next_seq;
  logic [3:0]                 word_op;
  logic [R-1:0]               word_ra;
  logic [R-1:0]               word_rb;
  logic [ROM_addressBits-1:0] word_target;

  // The branch target overlaps the register fields; the opcode decides which view applies.
  assign word_op     = ROM_data[4+2*R:1+2*R];
  assign word_ra     = ROM_data[2*R:R+1];
  assign word_rb     = ROM_data[R:1];
  assign word_target = ROM_data[ROM_addressBits-1:0];

  assign pc_next_seq = pc + PC_ONE;
  assign ROM_address = pc;

  // Strobe outputs are registered: they are loaded together with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= PC_ZERO;
      opcode         <= 4'b0000;
      ra             <= '0;
      rb             <= '0;
      instr_valid    <= 1'b0;
      halted         <= 1'b0;
      ROM_readEnable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pc <= PC_ZERO;
          if (start) begin
            state          <= FETCH;
            ROM_readEnable <= 1'b1;
          end
        end

        FETCH: begin
          state          <= DECODE;
          ROM_readEnable <= 1'b0;
        end

        DECODE: begin
          opcode <= word_op;
          ra     <= word_ra;
          rb     <= word_rb;
          case (word_op)
            OP_JMP: begin
              pc             <= word_target;
              state          <= FETCH;
              ROM_readEnable <= 1'b1;
            end
            OP_BRZ: begin
              pc             <= flag_z ? word_target : pc_next_seq;
              state          <= FETCH;
              ROM_readEnable <= 1'b1;
            end
            OP_BRN: begin
              pc             <= flag_n ? word_target : pc_next_seq;
              state          <= FETCH;
              ROM_readEnable <= 1'b1;
            end
            OP_HALT: begin
              state  <= HALT;
              halted <= 1'b1;
            end
            default: begin
              state       <= ISSUE;
              instr_valid <= 1'b1;
            end
          endcase
        end

        ISSUE: begin
          if (dp_ready) begin
            pc             <= pc_next_seq;
            state          <= FETCH;
            instr_valid    <= 1'b0;
            ROM_readEnable <= 1'b1;
          end
        end

        HALT: begin
          if (start) begin
            pc             <= PC_ZERO;
            state          <= FETCH;
            halted         <= 1'b0;
            ROM_readEnable <= 1'b1;
          end
        end

        default: begin
          state          <= IDLE;
          pc             <= PC_ZERO;
          instr_valid    <= 1'b0;
          halted         <= 1'b0;
          ROM_readEnable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed scenarios plus a random
// microprogram run against an instruction-level reference model of the sequencer.
module tb_microcode_sequencer;

  localparam int AW = 6;
  localparam int R  = 3;
  localparam int W  = 5 + 2*R;
  localparam int ROM_SIZE = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          dp_ready;
  logic          flag_z;
  logic          flag_n;
  logic          ROM_readEnable;
  logic [AW-1:0] ROM_address;
  logic [W-1:0]  ROM_data;
  logic [3:0]    opcode;
  logic [R-1:0]  ra;
  logic [R-1:0]  rb;
  logic          instr_valid;
  logic          halted;

  logic [W-1:0]  rom [0:ROM_SIZE-1];
  logic [W-1:0]  rom_q;

  int vectors;
  int miscompares;
  int m_pc;
  bit m_halted;

  microcode_sequencer #(.ROM_addressBits(AW), .RF_addressBits(R)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .dp_ready       (dp_ready),
    .flag_z         (flag_z),
    .flag_n         (flag_n),
    .ROM_readEnable (ROM_readEnable),
    .ROM_address    (ROM_address),
    .ROM_data       (ROM_data),
    .opcode         (opcode),
    .ra             (ra),
    .rb             (rb),
    .instr_valid    (instr_valid),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (ROM_readEnable) rom_q <= rom[ROM_address];
  end
  assign ROM_data = rom_q;

  function automatic logic [W-1:0] mk_dp(input logic [3:0] op, input int a, input int b);
    logic [R-1:0] fa;
    logic [R-1:0] fb;
    fa = R'(a);
    fb = R'(b);
    return {op, fa, fb, 1'b0};
  endfunction

  function automatic logic [W-1:0] mk_ctl(input logic [3:0] op, input int tgt);
    logic [W-1:0] w;
    w = '0;
    w[W-1:W-4] = op;
    w[AW-1:0]  = AW'(tgt);
    return w;
  endfunction

  task automatic fill_rom_halt();
    for (int i = 0; i < ROM_SIZE; i++) rom[i] = mk_ctl(4'hF, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    dp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 0;
    m_halted = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc = 0;
    m_halted = 1'b0;
  endtask

  // Executes one microinstruction from its FETCH cycle, predicting every cycle from the word in rom[m_pc].
  task automatic exec_instr(input int stall, input bit fz, input bit fn);
    logic [W-1:0] w;
    logic [3:0]   op;
    logic [R-1:0] exp_ra;
    logic [R-1:0] exp_rb;
    int           tgt;
    int           seq_pc;
    w      = rom[m_pc];
    op     = w[W-1:W-4];
    exp_ra = w[2*R:R+1];
    exp_rb = w[R:1];
    tgt    = int'(w[AW-1:0]);
    seq_pc = (m_pc + 1) % ROM_SIZE;

    vectors++;
    if (ROM_readEnable !== 1'b1 || ROM_address !== AW'(m_pc)) begin
      miscompares++;
      $display("[TB] FAIL fetch: got rd=%b addr=%0d, expected rd=1 addr=%0d", ROM_readEnable, ROM_address, m_pc);
    end
    vectors++;
    if (instr_valid !== 1'b0 || halted !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fetch_quiet: got valid=%b halted=%b, expected 0/0", instr_valid, halted);
    end
    start    = 1'($urandom_range(0, 1));
    dp_ready = 1'($urandom_range(0, 1));

    @(negedge clk);
    flag_z = fz;
    flag_n = fn;
    vectors++;
    if (ROM_readEnable !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL decode: got rd=%b valid=%b halted=%b, expected 0/0/0", ROM_readEnable, instr_valid, halted);
    end

    if (op == 4'hC) begin
      m_pc = tgt;
      @(negedge clk);
      start = 1'b0;
    end else if (op == 4'hD) begin
      m_pc = fz ? tgt : seq_pc;
      @(negedge clk);
      start = 1'b0;
    end else if (op == 4'hE) begin
      m_pc = fn ? tgt : seq_pc;
      @(negedge clk);
      start = 1'b0;
    end else if (op == 4'hF) begin
      @(negedge clk);
      start = 1'b0;
      m_halted = 1'b1;
      vectors++;
      if (halted !== 1'b1 || ROM_readEnable !== 1'b0 || instr_valid !== 1'b0 || ROM_address !== AW'(m_pc)) begin
        miscompares++;
        $display("[TB] FAIL halt_entry: got halted=%b rd=%b valid=%b addr=%0d, expected 1/0/0 addr=%0d",
                 halted, ROM_readEnable, instr_valid, ROM_address, m_pc);
      end
    end else begin
      for (int i = 0; i <= stall; i++) begin
        @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b1 || opcode !== op || ra !== exp_ra || rb !== exp_rb) begin
          miscompares++;
          $display("[TB] FAIL issue: got valid=%b op=%h ra=%0d rb=%0d, expected 1 op=%h ra=%0d rb=%0d",
                   instr_valid, opcode, ra, rb, op, exp_ra, exp_rb);
        end
        vectors++;
        if (ROM_readEnable !== 1'b0 || ROM_address !== AW'(m_pc) || halted !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL issue_hold: got rd=%b addr=%0d halted=%b, expected 0 addr=%0d 0",
                   ROM_readEnable, ROM_address, halted, m_pc);
        end
        dp_ready = (i == stall);
        start    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      dp_ready = 1'b0;
      start    = 1'b0;
      m_pc     = seq_pc;
    end
  endtask

  task automatic hold_halt(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      vectors++;
      if (halted !== 1'b1 || ROM_readEnable !== 1'b0 || instr_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL halt_hold: got halted=%b rd=%b valid=%b, expected 1/0/0", halted, ROM_readEnable, instr_valid);
      end
    end
  endtask

  task automatic check_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      vectors++;
      if (ROM_readEnable !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 || ROM_address !== '0) begin
        miscompares++;
        $display("[TB] FAIL idle: got rd=%b valid=%b halted=%b addr=%0d, expected 0/0/0 addr=0",
                 ROM_readEnable, instr_valid, halted, ROM_address);
      end
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    apply_reset();
    vectors++;
    if (opcode !== 4'h0 || ra !== '0 || rb !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_ir: got op=%h ra=%0d rb=%0d, expected 0/0/0", opcode, ra, rb);
    end
    check_idle(4);
  endtask

  task automatic test_basic_issue();
    $display("[TB] test_basic_issue");
    fill_rom_halt();
    rom[0] = mk_dp(4'b0001, 1, 2);
    apply_reset();
    do_start();
    exec_instr(0, 1'b0, 1'b0);
    exec_instr(0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    $display("[TB] test_stall");
    fill_rom_halt();
    rom[0] = mk_dp(4'b0101, 6, 3);
    apply_reset();
    do_start();
    exec_instr(5, 1'b0, 1'b0);
    exec_instr(0, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    $display("[TB] test_branch");
    fill_rom_halt();
    rom[0] = mk_ctl(4'hD, 5);
    apply_reset();
    do_start();
    exec_instr(0, 1'b1, 1'b0);
    exec_instr(0, 1'b0, 1'b0);
    do_start();
    exec_instr(0, 1'b0, 1'b1);
    exec_instr(0, 1'b0, 1'b0);
    rom[0] = mk_ctl(4'hE, 9);
    do_start();
    exec_instr(0, 1'b0, 1'b1);
    exec_instr(0, 1'b0, 1'b0);
    do_start();
    exec_instr(0, 1'b1, 1'b0);
    exec_instr(0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    $display("[TB] test_wrap");
    fill_rom_halt();
    rom[0]  = mk_ctl(4'hC, 63);
    rom[63] = mk_dp(4'b0110, 7, 4);
    apply_reset();
    do_start();
    exec_instr(0, 1'b0, 1'b0);
    exec_instr(0, 1'b0, 1'b0);
    exec_instr(0, 1'b0, 1'b0);
  endtask

  task automatic test_halt();
    $display("[TB] test_halt");
    fill_rom_halt();
    rom[0] = mk_dp(4'b0010, 3, 1);
    rom[1] = mk_dp(4'b1011, 2, 5);
    apply_reset();
    do_start();
    exec_instr(0, 1'b0, 1'b0);
    exec_instr(1, 1'b0, 1'b0);
    exec_instr(0, 1'b0, 1'b0);
    hold_halt(4);
    do_start();
    exec_instr(0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_flight();
    $display("[TB] test_reset_mid_flight");
    fill_rom_halt();
    rom[0] = mk_ctl(4'hC, 3);
    rom[3] = mk_dp(4'b0011, 5, 7);
    apply_reset();
    do_start();
    exec_instr(0, 1'b0, 1'b0);
    @(negedge clk);
    dp_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || ROM_address !== AW'(3)) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_issue: got valid=%b addr=%0d, expected 1 addr=3", instr_valid, ROM_address);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (instr_valid !== 1'b0 || ROM_address !== '0 || opcode !== 4'h0 || ra !== '0 || rb !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_issue: got valid=%b addr=%0d op=%h ra=%0d rb=%0d, expected all 0",
               instr_valid, ROM_address, opcode, ra, rb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dp_ready = 1'b1;
    check_idle(4);
    dp_ready = 1'b0;
    do_start();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (ROM_readEnable !== 1'b0 || halted !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_fetch: got rd=%b halted=%b, expected 0/0", ROM_readEnable, halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(3);
    do_start();
    exec_instr(0, 1'b0, 1'b0);
  endtask

  task automatic test_random_program();
    $display("[TB] test_random_program");
    for (int i = 0; i < ROM_SIZE; i++) rom[i] = W'($urandom);
    apply_reset();
    do_start();
    for (int n = 0; n < 300; n++) begin
      exec_instr(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (m_halted) begin
        hold_halt(int'($urandom_range(0, 2)));
        do_start();
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m_pc = 0;
    m_halted = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    dp_ready = 1'b0;
    flag_z = 1'b0;
    flag_n = 1'b0;
    fill_rom_halt();
    test_reset();
    test_basic_issue();
    test_stall();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_mid_flight();
    test_random_program();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
